// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
//
// General-purpose register file for the single-cycle CPU: 2**DEPTH_LOG2
// entries of WIDTH bits, one write port, two operand read ports and one
// debug read port. Register 0 is hardwired to zero and has no storage.
//
// The write-back word is steered into exactly one register by a one-hot
// decode of the destination number. Reads are purely combinational.
//
// Parameters
//   WIDTH       data width of every register and data port
//   DEPTH_LOG2  register-number width (file holds 2**DEPTH_LOG2 entries)
//   BYPASS      1: qa/qb return same-cycle write data on an address match
//               0: qa/qb return stored contents only
//
// Ports
//   clk     clock, writes commit on the rising edge
//   clrn    asynchronous active-low reset (clears r1..rN and wr_cnt)
//   rna     read port A register number   -> qa
//   rnb     read port B register number   -> qb
//   rnd     debug read register number    -> qd (never bypassed)
//   we      write enable
//   wn      destination register number
//   d       write data
//   wr_cnt  number of committed writes to non-zero registers (wraps)
// ---------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [DEPTH_LOG2-1:0] rna,
  input  logic [DEPTH_LOG2-1:0] rnb,
  input  logic [DEPTH_LOG2-1:0] rnd,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wn,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      qa,
  output logic [WIDTH-1:0]      qb,
  output logic [WIDTH-1:0]      qd,
  output logic [31:0]           wr_cnt
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam bit BYP_EN = (BYPASS != 0);

  // One-hot destination decode. Bit 0 is never set: a write to register 0
  // is discarded, and so is any write while reset is held.
  function automatic logic [DEPTH-1:0] decode_dest(
    input logic                  en,
    input logic [DEPTH_LOG2-1:0] num
  );
    logic [DEPTH-1:0] sel;
    sel = '0;
    if (en && (num != '0)) begin
      sel[num] = 1'b1;
    end
    return sel;
  endfunction

  // Read-port data selection. While reset is asserted every port reads 0,
  // including a bypassed port that would otherwise forward d.
  function automatic logic [WIDTH-1:0] read_sel(
    input logic                  rst_active,
    input logic                  byp_allowed,
    input logic                  wr_commit_i,
    input logic [DEPTH_LOG2-1:0] rd_num,
    input logic [DEPTH_LOG2-1:0] wr_num,
    input logic [WIDTH-1:0]      wr_data,
    input logic [WIDTH-1:0]      stored
  );
    logic [WIDTH-1:0] res;
    res = stored;
    if (rst_active) begin
      res = '0;
    end else if (byp_allowed && wr_commit_i && (rd_num == wr_num)) begin
      res = wr_data;
    end
    return res;
  endfunction

  logic             wr_commit;
  logic [DEPTH-1:0] wr_onehot;
  logic [WIDTH-1:0] rd_view [DEPTH];
  logic [31:0]      wr_cnt_q;

  // A write commits only when out of reset, enabled, and not aimed at r0.
  assign wr_commit = clrn & we & (wn != '0);
  assign wr_onehot = decode_dest(wr_commit, wn);

  // Register 0 has no storage; its read view is a constant zero.
  assign rd_view[0] = '0;

  // Storage for r1..r(DEPTH-1). Each entry loads only when its decode bit
  // is set, so no other register can change on a write.
  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        q <= '0;
      end else if (wr_onehot[i]) begin
        q <= d;
      end
    end

    assign rd_view[i] = q;
  end

  // Committed-write counter; wraps silently at 2**32.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_cnt_q <= '0;
    end else if (wr_commit) begin
      wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign wr_cnt = wr_cnt_q;

  // Read ports. The debug port never forwards write data so it always
  // shows committed architectural state.
  always_comb begin
    qa = read_sel(!clrn, BYP_EN, wr_commit, rna, wn, d, rd_view[rna]);
    qb = read_sel(!clrn, BYP_EN, wr_commit, rnb, wn, d, rd_view[rnb]);
    qd = read_sel(!clrn, 1'b0,   wr_commit, rnd, wn, d, rd_view[rnd]);
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// tb_reg_file_2r1w
//
// Directed bench for reg_file_2r1w. Two instances share every input: one
// built with BYPASS=0 (dut) and one with BYPASS=1 (dut_byp), so both read
// behaviours are observed on the same stimulus. Inputs change on the
// falling edge; outputs are sampled 1 ns after a change or a rising edge.
// ---------------------------------------------------------------------------
module tb_reg_file_2r1w;

  localparam int WIDTH      = 32;
  localparam int DEPTH_LOG2 = 5;

  logic                  clk;
  logic                  clrn;
  logic [DEPTH_LOG2-1:0] rna, rnb, rnd, wn;
  logic                  we;
  logic [WIDTH-1:0]      d;
  logic [WIDTH-1:0]      qa0, qb0, qd0;
  logic [WIDTH-1:0]      qa1, qb1, qd1;
  logic [31:0]           cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_2r1w #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(0)) dut (
    .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .rnd(rnd),
    .we(we), .wn(wn), .d(d), .qa(qa0), .qb(qb0), .qd(qd0), .wr_cnt(cnt0)
  );

  reg_file_2r1w #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(1)) dut_byp (
    .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .rnd(rnd),
    .we(we), .wn(wn), .d(d), .qa(qa1), .qb(qb1), .qd(qd1), .wr_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [DEPTH_LOG2-1:0] num, input logic [31:0] val);
    @(negedge clk);
    we = 1'b1; wn = num; d = val;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; we = 1'b0; wn = '0; d = '0;
    rna = 5'd5; rnb = 5'd5; rnd = 5'd5;

    // ---- reset state ----
    #12;
    check("rst_qa", qa0, 32'h0);
    check("rst_cnt", cnt0, 32'h0);
    @(negedge clk);
    clrn = 1'b1;

    // ---- asynchronous reset clears a preloaded register ----
    write_reg(5'd5, 32'h1234_5678);
    check("preload_r5", qa0, 32'h1234_5678);
    check("preload_cnt", cnt0, 32'd1);
    @(negedge clk);
    we = 1'b1; wn = 5'd9; d = 32'hCAFE_F00D; rnb = 5'd9;
    #2 clrn = 1'b0;
    #1;
    check("async_rst_qa", qa0, 32'h0);
    check("async_rst_cnt", cnt0, 32'h0);
    check("async_rst_byp_qb", qb1, 32'h0);
    @(posedge clk); #1;
    check("rst_write_ignored", qb0, 32'h0);
    check("rst_write_ignored_byp", qb1, 32'h0);
    @(negedge clk);
    we = 1'b0; clrn = 1'b1;
    #1;
    check("post_rst_r9", qb0, 32'h0);
    check("post_rst_cnt", cnt0, 32'h0);

    // ---- write decode sweep ----
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'hA500_0000 | 32'(i));
    end
    @(negedge clk);
    for (int i = 1; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(i); rnd = 5'(i);
      #1;
      check($sformatf("sweep_qa_r%0d", i), qa0, 32'hA500_0000 | 32'(i));
      check($sformatf("sweep_qb_r%0d", i), qb0, 32'hA500_0000 | 32'(i));
      check($sformatf("sweep_qd_r%0d", i), qd0, 32'hA500_0000 | 32'(i));
      check($sformatf("sweep_byp_qa_r%0d", i), qa1, 32'hA500_0000 | 32'(i));
    end
    check("sweep_cnt", cnt0, 32'd31);
    check("sweep_cnt_byp", cnt1, 32'd31);

    // ---- register 0 ----
    @(negedge clk);
    we = 1'b1; wn = 5'd0; d = 32'hFFFF_FFFF; rna = 5'd0; rnb = 5'd0; rnd = 5'd0;
    #1;
    check("r0_pre_qa", qa0, 32'h0);
    check("r0_pre_byp_qa", qa1, 32'h0);
    @(posedge clk); #1;
    check("r0_post_qa", qa0, 32'h0);
    check("r0_post_qd", qd0, 32'h0);
    check("r0_post_byp_qb", qb1, 32'h0);
    check("r0_cnt", cnt0, 32'd31);
    we = 1'b0;

    // ---- read during write ----
    write_reg(5'd7, 32'h1111_1111);
    @(negedge clk);
    we = 1'b1; wn = 5'd7; d = 32'h2222_2222; rna = 5'd7; rnb = 5'd7; rnd = 5'd7;
    #1;
    check("rdw_pre_qa", qa0, 32'h1111_1111);
    check("rdw_pre_qb", qb0, 32'h1111_1111);
    check("rdw_pre_qd", qd0, 32'h1111_1111);
    check("rdw_byp_pre_qa", qa1, 32'h2222_2222);
    check("rdw_byp_pre_qb", qb1, 32'h2222_2222);
    check("rdw_byp_pre_qd", qd1, 32'h1111_1111);
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    check("rdw_post_qa", qa0, 32'h2222_2222);
    check("rdw_post_qd", qd0, 32'h2222_2222);
    check("rdw_cnt", cnt0, 32'd33);

    // ---- we=0 holds all state ----
    @(negedge clk);
    we = 1'b0; wn = 5'd3; d = 32'hDEAD_BEEF; rna = 5'd3; rnb = 5'd3; rnd = 5'd3;
    repeat (10) @(posedge clk);
    #1;
    check("hold_r3", qa0, 32'hA500_0003);
    check("hold_r3_byp", qb1, 32'hA500_0003);
    check("hold_cnt", cnt0, 32'd33);
    check("hold_cnt_byp", cnt1, 32'd33);

    // ---- counter wrap ----
    @(negedge clk);
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.wr_cnt_q;
    #1;
    check("wrap_preset", cnt0, 32'hFFFF_FFFF);
    write_reg(5'd4, 32'h0000_0044);
    rna = 5'd4;
    #1;
    check("wrap_cnt", cnt0, 32'h0);
    check("wrap_r4", qa0, 32'h0000_0044);
    check("wrap_cnt_byp", cnt1, 32'd34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
